// File: rtl/delay_sequencer.sv
// delay_sequencer: multi-channel trigger scheduler.
// Armed by software, started by a strobe, then one shared time counter
// drives NUM_CH delayed pulses (per-channel delay/width) repeated for a
// programmable number of shots at a fixed period. All run parameters are
// shadowed when the strobe is accepted.
//
// Optional feature: define DELAY_SEQUENCER_MISSED_CNT_EN to add missed_o,
// a saturating count of strobes that arrive while a run is in progress.
//
// Timing model: t is the time inside the current shot and equals 0 in
// the first cycle after the accepted strobe. Every output is registered
// from next-cycle values, so pulse_o, done_o and shot_cnt_o line up with
// t in the same cycle.
module delay_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int REP_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    arm_i,
    input  logic                    disarm_i,
    input  logic                    strobe_i,
    input  logic [CNT_W-1:0]        period_i,
    input  logic [REP_W-1:0]        repeat_i,
    input  logic [NUM_CH*CNT_W-1:0] delay_i,
    input  logic [NUM_CH*CNT_W-1:0] width_i,
    output logic [NUM_CH-1:0]       pulse_o,
    output logic                    armed_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [REP_W-1:0]        shot_cnt_o
`ifdef DELAY_SEQUENCER_MISSED_CNT_EN
    ,
    output logic [REP_W-1:0]        missed_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        t_q, t_d;
    logic [REP_W-1:0]        shot_d;
    logic                    done_d;
    logic [NUM_CH-1:0]       pulse_d;

    // Shadow copies of the run parameters, captured on the accepted strobe.
    logic [CNT_W-1:0]        period_q;
    logic [REP_W-1:0]        repeat_q;
    logic [NUM_CH*CNT_W-1:0] delay_q;
    logic [NUM_CH*CNT_W-1:0] width_q;

    // Values the shadows will hold next cycle; the strobe cycle already
    // needs the new parameters to compute the first registered outputs.
    logic                    accept;
    logic [CNT_W-1:0]        period_d;
    logic [REP_W-1:0]        repeat_d;
    logic [NUM_CH*CNT_W-1:0] delay_d;
    logic [NUM_CH*CNT_W-1:0] width_d;
    logic [CNT_W-1:0]        p_last;

    assign accept   = (state_q == S_ARMED) && !disarm_i && strobe_i;
    assign period_d = accept ? period_i : period_q;
    assign repeat_d = accept ? repeat_i : repeat_q;
    assign delay_d  = accept ? delay_i  : delay_q;
    assign width_d  = accept ? width_i  : width_q;

    // Last time value of a shot; a zero period behaves as a period of one.
    assign p_last = (period_d == '0) ? '0 : period_d - 1'b1;

    assign armed_o = (state_q == S_ARMED);
    assign busy_o  = (state_q == S_RUN);

    // Window test with the end computed one bit wider so delay+width never wraps.
    function automatic logic in_window(input logic [CNT_W-1:0] t,
                                       input logic [CNT_W-1:0] d,
                                       input logic [CNT_W-1:0] w);
        logic [CNT_W:0] stop;
        stop = {1'b0, d} + {1'b0, w};
        return (t >= d) && ({1'b0, t} < stop);
    endfunction

    // Next state, next time value, next shot count, done and pulse lookahead.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d = state_q;
        t_d     = t_q;
        shot_d  = shot_cnt_o;
        done_d  = 1'b0;
        pulse_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (arm_i && !disarm_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (disarm_i) begin
                    state_d = S_IDLE;
                end else if (strobe_i) begin
                    state_d = S_RUN;
                    t_d     = '0;
                    shot_d  = '0;
                end
            end
            S_RUN: begin
                if (disarm_i) begin
                    state_d = S_IDLE;
                end else if (t_q == p_last) begin
                    // done_o is high exactly in the last cycle of the final shot.
                    if (done_o) state_d = S_IDLE;
                    else        t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A shot counts as completed in its last cycle, together with done_o.
        if (state_d == S_RUN && t_d == p_last) begin
            shot_d = shot_d + 1'b1;
            done_d = (repeat_d != '0) && (shot_d == repeat_d);
        end

        for (int k = 0; k < NUM_CH; k++) begin
            pulse_d[k] = (state_d == S_RUN) &&
                         in_window(t_d, delay_d[k*CNT_W +: CNT_W],
                                   width_d[k*CNT_W +: CNT_W]);
        end
    end

    // Sequencer state and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            pulse_o    <= '0;
            done_o     <= 1'b0;
            shot_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            pulse_o    <= pulse_d;
            done_o     <= done_d;
            shot_cnt_o <= shot_d;
        end
    end

    // Shadow parameter capture on the accepted strobe.
    always_ff @(posedge clk_i) begin
        // NOTE: shadows have no reset; they are only read in RUN, which always loads them first.
        if (accept) begin
            period_q <= period_i;
            repeat_q <= repeat_i;
            delay_q  <= delay_i;
            width_q  <= width_i;
        end
    end

`ifdef DELAY_SEQUENCER_MISSED_CNT_EN
    // Saturating count of strobes that arrive during a run.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            missed_o <= '0;
        end else if (accept) begin
            missed_o <= '0;
        end else if (state_q == S_RUN && strobe_i && missed_o != '1) begin
            missed_o <= missed_o + 1'b1;
        end
    end
`else
    // Strobes during a run are dropped without any record.
`endif

endmodule
